// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and stage payload for the CORDIC cosine.
// Q2.30 fixed point throughout; CORDIC_ROUND_EN selects mantissa rounding.
package cordic_pkg;

    localparam int CF_FRAC     = 30;
    localparam int CF_W        = CF_FRAC + 2;
    localparam int CF_ITER_MAX = 24;

    localparam logic [7:0] CF_EXP_TINY = 8'd115;
    localparam logic [7:0] CF_EXP_BIG  = 8'd128;

    localparam logic [CF_W-1:0] CF_K   = 32'h26DD3B6A;
    localparam logic [31:0]     CF_NAN = 32'h7FC00000;
    localparam logic [31:0]     CF_ONE = 32'h3F800000;

    // atan(2^-i) in Q2.30, i = 0 first
    localparam logic [0:CF_ITER_MAX-1][CF_W-1:0] CF_ATAN = {
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F
    };

    typedef struct packed {
        logic signed [CF_W-1:0] x;
        logic signed [CF_W-1:0] y;
        logic signed [CF_W-1:0] z;
        logic                   spec;
        logic [31:0]            sval;
    } stage_t;

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift index I.
// Special-case flag and value ride along untouched.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int I = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t s_i,
    output stage_t s_o
);

    stage_t s_d, s_q;
    logic signed [CF_W-1:0] xs, ys;

    always_comb begin
        s_d = s_q;
        xs  = $signed(s_i.x) >>> I;
        ys  = $signed(s_i.y) >>> I;
        if (en) begin
            s_d = s_i;
            if (!s_i.z[CF_W-1]) begin
                s_d.x = s_i.x - ys;
                s_d.y = s_i.y + xs;
                s_d.z = s_i.z - CF_ATAN[I];
            end else begin
                s_d.x = s_i.x + ys;
                s_d.y = s_i.y - xs;
                s_d.z = s_i.z + CF_ATAN[I];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) s_q <= '0;
        else     s_q <= s_d;
    end

    assign s_o = s_q;

endmodule

// File: rtl/cordic_cos.sv
// binary32 cosine: unpack stage, ITER CORDIC rotations, pack stage.
// Define CORDIC_ROUND_EN for round-to-nearest-even packing.
module cordic_cos
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int FRAC = 30
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    output logic [31:0] result
);

    if (FRAC != CF_FRAC || ITER < 12 || ITER > CF_ITER_MAX) begin : g_bad_cfg
        $error("cordic_cos: unsupported FRAC/ITER");
    end

    stage_t s0_d, s0_q;
    stage_t pipe [0:ITER];
    logic [7:0]      ex;
    logic [CF_W-1:0] mfix;
    logic            unused_sign;

    assign unused_sign = dataa[31];

    // mfix holds 2*(1.f) in Q2.30; shift brings it to 1.f * 2^(ex-127)
    always_comb begin
        ex   = dataa[30:23];
        mfix = {1'b1, dataa[22:0], {(CF_W-24){1'b0}}};
        s0_d = s0_q;
        if (clk_en) begin
            s0_d.x    = CF_K;
            s0_d.y    = '0;
            s0_d.z    = mfix >> (8'd128 - ex);
            s0_d.spec = 1'b0;
            s0_d.sval = '0;
            if (ex >= CF_EXP_BIG) begin
                s0_d.spec = 1'b1;
                s0_d.sval = CF_NAN;
            end else if (ex < CF_EXP_TINY) begin
                s0_d.spec = 1'b1;
                s0_d.sval = CF_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) s0_q <= '0;
        else      s0_q <= s0_d;
    end

    assign pipe[0] = s0_q;

    for (genvar g = 0; g < ITER; g++) begin : g_rot
        cordic_stage #(.I(g)) u_stage (
            .clk (clock),
            .rst (aclr),
            .en  (clk_en),
            .s_i (pipe[g]),
            .s_o (pipe[g+1])
        );
    end

    stage_t          fin;
    logic [CF_W-1:0] mag, nrm;
    logic [5:0]      lead;
    logic [22:0]     mant;
    logic [7:0]      expo;
    logic [31:0]     res_d, res_q;
    logic            unused_tail;

    assign unused_tail = ^{fin.y, fin.z, nrm[CF_W-1]};

`ifdef CORDIC_ROUND_EN
    logic        rnd, stk;
    logic [23:0] msum;
`else
    logic        unused_guard;
    assign unused_guard = |nrm[CF_W-25:0];
`endif

    always_comb begin
        fin  = pipe[ITER];
        mag  = fin.x[CF_W-1] ? CF_W'(-fin.x) : fin.x;
        lead = '0;
        for (int b = 0; b < CF_W; b++) begin
            if (mag[b]) lead = 6'(b);
        end
        nrm  = mag << (6'(CF_W-1) - lead);
        mant = nrm[CF_W-2 -: 23];
        expo = 8'(127 - CF_FRAC) + {2'b00, lead};
`ifdef CORDIC_ROUND_EN
        rnd  = nrm[CF_W-25];
        stk  = |nrm[CF_W-26:0];
        msum = {1'b0, mant} + {23'd0, rnd & (stk | mant[0])};
        if (msum[23]) expo = expo + 8'd1;
        mant = msum[22:0];
`endif
        res_d = res_q;
        if (clk_en) begin
            if (fin.spec)       res_d = fin.sval;
            else if (mag == '0) res_d = '0;
            else                res_d = {fin.x[CF_W-1], expo, mant};
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) res_q <= '0;
        else      res_q <= res_d;
    end

    assign result = res_q;

endmodule

// File: tb/tb_cordic_cos.sv
// Self-checking bench for cordic_cos: vector table, corner sequences,
// and a randomized stream scored against a real-valued cosine model.
module tb_cordic_cos;

    localparam int LAT = 18;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic [31:0] dataa;
    logic [31:0] result;

    always #5 clock = ~clock;

    cordic_cos #(.ITER(16), .FRAC(30)) dut (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .dataa  (dataa),
        .result (result)
    );

    typedef struct {
        bit          zero;
        logic [31:0] a;
    } ent_t;

    typedef struct {
        string       nm;
        logic [31:0] a;
        bit          exact;
        logic [31:0] want;
        real         wval;
    } vec_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        if (v == 0.0) return 32'h0;
        d = $realtobits(v);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic chk_bits(input string nm, input logic [31:0] got,
                            input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_near(input string nm, input logic [31:0] got,
                            input real want);
        real g;
        checks++;
        g = f2r(got);
        if ($isunknown(got) || got[30:23] == 8'hFF || rabs(g - want) > 4.0e-5) begin
            errors++;
            $display("FAIL %s got %h (%f) want %f", nm, got, g, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // reference: what cos() of a sampled input must look like
    task automatic judge(input ent_t e, input logic [31:0] r);
        logic [7:0] ex;
        real        ang;
        if (e.zero) begin
            chk_bits("flush", r, 32'h0);
        end else begin
            ex  = e.a[30:23];
            ang = f2r({1'b0, e.a[30:0]});
            if (ex >= 8'd128) begin
                chk_bits("nan", r, 32'h7FC00000);
            end else if (ex < 8'd115) begin
                chk_bits("tiny", r, 32'h3F800000);
            end else if (ang <= 1.57) begin
                chk_near("cos", r, $cos(ang));
            end else begin
                checks++;
                if ($isunknown(r) || r[30:23] == 8'hFF) begin
                    errors++;
                    $display("FAIL finite got %h for %h", r, e.a);
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [31:0] d);
        @(negedge clock);
        aclr   = rst;
        clk_en = en;
        dataa  = d;
        @(posedge clock);
        #1;
        if (rst) begin
            q.delete();
            repeat (LAT) q.push_back('{zero: 1'b1, a: 32'h0});
        end else if (en) begin
            q.push_back('{zero: 1'b0, a: d});
            void'(q.pop_front());
        end
        if (q.size() == LAT) judge(q[0], result);
    endtask

    vec_t tbl[15];
    logic [31:0] r1, r2, r3;
    int hits, first;

    initial begin
        aclr   = 1'b1;
        clk_en = 1'b0;
        dataa  = 32'h0;

        tbl[0]  = '{"cos_0525", 32'h3F066B2D, 1'b0, 32'h0, 0.865287};
        tbl[1]  = '{"cos_1",    32'h3F800000, 1'b0, 32'h0, 0.540302};
        tbl[2]  = '{"cos_m1",   32'hBF800000, 1'b0, 32'h0, 0.540302};
        tbl[3]  = '{"cos_pi4",  32'h3F490FDB, 1'b0, 32'h0, 0.707107};
        tbl[4]  = '{"cos_157",  32'h3FC8F5C3, 1'b0, 32'h0, 0.000796};
        tbl[5]  = '{"p2m12",    32'h39800000, 1'b0, 32'h0, 1.0};
        tbl[6]  = '{"zero",     32'h00000000, 1'b1, 32'h3F800000, 0.0};
        tbl[7]  = '{"negzero",  32'h80000000, 1'b1, 32'h3F800000, 0.0};
        tbl[8]  = '{"denorm",   32'h00000001, 1'b1, 32'h3F800000, 0.0};
        tbl[9]  = '{"p2m13",    32'h39000000, 1'b1, 32'h3F800000, 0.0};
        tbl[10] = '{"qnan",     32'h7FC00000, 1'b1, 32'h7FC00000, 0.0};
        tbl[11] = '{"inf",      32'h7F800000, 1'b1, 32'h7FC00000, 0.0};
        tbl[12] = '{"three",    32'h40400000, 1'b1, 32'h7FC00000, 0.0};
        tbl[13] = '{"two",      32'h40000000, 1'b1, 32'h7FC00000, 0.0};
        tbl[14] = '{"ninf",     32'hFF800000, 1'b1, 32'h7FC00000, 0.0};

        // reset for two cycles, then idle with clk_en low
        step(1'b1, 1'b1, 32'h3F800000);
        step(1'b1, 1'b0, 32'h3F800000);
        chk_bits("reset_out", result, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h3F800000);
        chk_bits("reset_hold", result, 32'h0);

        foreach (tbl[k]) begin
            step(1'b0, 1'b1, tbl[k].a);
            repeat (LAT - 1) step(1'b0, 1'b1, 32'h0);
            if (tbl[k].exact) chk_bits(tbl[k].nm, result, tbl[k].want);
            else              chk_near(tbl[k].nm, result, tbl[k].wval);
        end

        // back-to-back samples keep order
        step(1'b0, 1'b1, 32'h3F800000);
        step(1'b0, 1'b1, 32'hBF800000);
        step(1'b0, 1'b1, 32'h00000000);
        repeat (LAT - 3) step(1'b0, 1'b1, 32'h40400000);
        r1 = result;
        step(1'b0, 1'b1, 32'h40400000);
        r2 = result;
        step(1'b0, 1'b1, 32'h40400000);
        r3 = result;
        chk_near("stream_a", r1, 0.540302);
        chk_bits("stream_b", r2, r1);
        chk_bits("stream_c", r3, 32'h3F800000);

        // five stalled cycles delay pi/4 by exactly five
        hits  = 0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, !(i >= 7 && i <= 11), (i == 1) ? 32'h3F490FDB : 32'h0);
            if (rabs(f2r(result) - 0.707107) < 4.0e-5) begin
                hits++;
                if (first == 0) first = i;
            end
        end
        chk_int("stall_arrival", first, LAT + 5);
        chk_int("stall_count", hits, 1);

        // reset with ten samples in flight
        repeat (10) step(1'b0, 1'b1, 32'h3F800000);
        step(1'b1, 1'b1, 32'h3F800000);
        chk_bits("flush_now", result, 32'h0);
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b1, 32'h0);
            if (rabs(f2r(result) - 0.540302) < 1.0e-3) hits++;
        end
        chk_int("flush_lost", hits, 0);
        chk_bits("flush_after", result, 32'h3F800000);

        // randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            int   r;
            real  v;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            v = real'($urandom_range(0, 157000)) / 100000.0;
            d = r2f(v);
            if ($urandom_range(0, 1) == 1) d[31] = 1'b1;
            if (r >= 70) d = $urandom;
            step(r == 0, r >= 10, d);
        end
        repeat (LAT) step(1'b0, 1'b1, 32'h3F000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
